// File: rtl/ram32k_arbiter.sv
// Two-port byte/half/word arbiter onto a byte-wide RAM; ack at T+n+2 (3/4/6 cycles); loser holds req until granted.
// Fixed priority by FIXED_WINNER by default; define RAM32K_ARB_RR_EN for round-robin arbitration.
module ram32k_arbiter #(
  parameter int AW           = 15,
  parameter int FIXED_WINNER = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [1:0]    p0_size,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_ack,
  output logic [31:0]   p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [1:0]    p1_size,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_ack,
  output logic [31:0]   p1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, XFER, WAIT, ACK} state_t;

  state_t        state_q, state_d;
  logic          id_q, we_q;
  logic [1:0]    last_q, k_q, k_prev;
  logic [31:0]   wdata_q, rbuf_q, rd_final;
  logic          gnt_vld, gnt_id;
  logic          sel_we;
  logic [1:0]    sel_size, sel_last;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;

`ifdef RAM32K_ARB_RR_EN
  logic lg_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      lg_q <= 1'b1;
    else if (state_q == IDLE && gnt_vld)
      lg_q <= gnt_id;
  end
`endif

  always_comb begin
    gnt_vld = p0_req | p1_req;
    gnt_id  = p1_req;
    if (p0_req && p1_req) begin
`ifdef RAM32K_ARB_RR_EN
      gnt_id = ~lg_q;
`else
      gnt_id = (FIXED_WINNER != 0);
`endif
    end
  end

  always_comb begin
    sel_we    = gnt_id ? p1_we    : p0_we;
    sel_size  = gnt_id ? p1_size  : p0_size;
    sel_addr  = gnt_id ? p1_addr  : p0_addr;
    sel_wdata = gnt_id ? p1_wdata : p0_wdata;
    case (sel_size)
      2'b00:   sel_last = 2'd0;
      2'b01:   sel_last = 2'd1;
      default: sel_last = 2'd3;
    endcase
  end

  // Final byte comes straight from ram_dout so rdata is ready in the ACK cycle.
  always_comb begin
    k_prev   = k_q - 2'd1;
    rd_final = rbuf_q;
    rd_final[{last_q, 3'b000} +: 8] = ram_dout;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    ram_we  = 1'b0;
    ram_din = wdata_q[{k_q, 3'b000} +: 8];
    p0_ack  = 1'b0;
    p1_ack  = 1'b0;
    case (state_q)
      IDLE: if (gnt_vld) state_d = XFER;
      XFER: begin
        ram_we = we_q & rst_n;
        if (k_q == last_q) state_d = WAIT;
      end
      WAIT: state_d = ACK;
      ACK: begin
        p0_ack  = ~id_q;
        p1_ack  = id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      last_q   <= 2'd0;
      k_q      <= 2'd0;
      wdata_q  <= 32'd0;
      rbuf_q   <= 32'd0;
      ram_addr <= '0;
      p0_rdata <= 32'd0;
      p1_rdata <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            id_q     <= gnt_id;
            we_q     <= sel_we;
            last_q   <= sel_last;
            wdata_q  <= sel_wdata;
            ram_addr <= sel_addr;
            k_q      <= 2'd0;
            rbuf_q   <= 32'd0;
          end
        end
        XFER: begin
          // Registered RAM: the byte addressed last cycle is on ram_dout now.
          if (k_q != 2'd0)
            rbuf_q[{k_prev, 3'b000} +: 8] <= ram_dout;
          k_q <= k_q + 2'd1;
          if (k_q != last_q)
            ram_addr <= ram_addr + AW'(1);
        end
        WAIT: begin
          if (!we_q) begin
            if (id_q)
              p1_rdata <= rd_final;
            else
              p0_rdata <= rd_final;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram32k_arbiter.sv
// Randomized self-checking bench for ram32k_arbiter against a byte-array memory model.
module tb_ram32k_arbiter;
  localparam int AW  = 15;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [1:0]    p0_size, p1_size;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [31:0]   p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic          p0_ack, p1_ack;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din, ram_dout;
  logic          ram_we, busy;

  logic [7:0]    mem     [0:MSZ-1];
  logic [7:0]    ref_mem [0:MSZ-1];
  logic [31:0]   exp_rdata [2];
  int            checks = 0, failures = 0;
  int            both_ack_cnt = 0, idle_we_cnt = 0;

  always #5 clk = ~clk;

  ram32k_arbiter #(.AW(AW), .FIXED_WINNER(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout), .busy(busy)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (p0_ack && p1_ack) both_ack_cnt++;
    if (ram_we && !busy) idle_we_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input int addr, input int n);
    logic [31:0] r = 32'd0;
    for (int b = 0; b < n; b++) r[8*b +: 8] = ref_mem[(addr + b) % MSZ];
    return r;
  endfunction

  function automatic int size_bytes(input int size);
    return (size == 0) ? 1 : (size == 1) ? 2 : 4;
  endfunction

  function automatic logic get_ack(input int port);
    return (port == 0) ? p0_ack : p1_ack;
  endfunction

  function automatic logic [31:0] get_rdata(input int port);
    return (port == 0) ? p0_rdata : p1_rdata;
  endfunction

  task automatic set_cmd(input int port, input logic req, input logic we, input logic [1:0] size,
                         input logic [AW-1:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_size = size; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_size = size; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 100) chk("idle_timeout", guard, 0);
  endtask

  // Runs one transaction; with disturb set, the command inputs are scrambled mid-transfer.
  task automatic do_op(input int port, input bit we, input int size, input int addr,
                       input logic [31:0] wdata, input bit disturb);
    int n = size_bytes(size);
    int cyc = 0;
    bit got = 0;
    logic [31:0] exp;
    wait_idle();
    set_cmd(port, 1'b1, we, 2'(size), AW'(addr), wdata);
    while (cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (disturb && cyc == 2) set_cmd(port, 1'b1, ~we, 2'(size), AW'(addr + 256), ~wdata);
      if (get_ack(port)) begin got = 1; break; end
    end
    chk($sformatf("latency p%0d n%0d", port, n), cyc, n + 2);
    if (we) begin
      exp = exp_rdata[port];
      for (int b = 0; b < n; b++) ref_mem[(addr + b) % MSZ] = wdata[8*b +: 8];
    end else begin
      exp = ref_read(addr, n);
      exp_rdata[port] = exp;
    end
    chk($sformatf("rdata p%0d a%h", port, addr), get_rdata(port), exp);
    chk("loser_ack", get_ack(1 - port), 1'b0);
    chk("loser_rdata", get_rdata(1 - port), exp_rdata[1 - port]);
    set_cmd(port, 1'b0, 1'b0, 2'd0, '0, 32'd0);
    @(posedge clk); #1;
    chk("ack_one_cycle", get_ack(port), 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("we_in_reset", ram_we, 1'b0);
    rst_n = 1'b1;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int gid [4];
    int gcnt;
    int cyc;
    for (int i = 0; i < MSZ; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    set_cmd(0, 1'b0, 1'b0, 2'd0, '0, 32'd0);
    set_cmd(1, 1'b0, 1'b0, 2'd0, '0, 32'd0);
    ram_dout = 8'h00;
    do_reset();

    chk("rst_p0_ack", p0_ack, 1'b0);
    chk("rst_p1_ack", p1_ack, 1'b0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);
    chk("rst_p1_rdata", p1_rdata, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_we", ram_we, 1'b0);

    do_op(1, 1, 2, 'h0100, 32'hDEADBEEF, 0);
    do_op(0, 0, 2, 'h0100, 32'h0, 0);
    chk("p0_word_read", p0_rdata, 32'hDEADBEEF);
    chk("mem_0100", mem['h0100], 8'hEF);
    chk("mem_0101", mem['h0101], 8'hBE);
    chk("mem_0102", mem['h0102], 8'hAD);
    chk("mem_0103", mem['h0103], 8'hDE);
    do_op(0, 0, 1, 'h0101, 32'h0, 0);
    chk("half_read", p0_rdata, 32'h0000ADBE);
    do_op(0, 0, 0, 'h0103, 32'h0, 0);
    chk("byte_read", p0_rdata, 32'h000000DE);

    do_op(1, 1, 3, 'h7FFE, 32'h11223344, 0);
    chk("wrap_7ffe", mem['h7FFE], 8'h44);
    chk("wrap_7fff", mem['h7FFF], 8'h33);
    chk("wrap_0000", mem['h0000], 8'h22);
    chk("wrap_0001", mem['h0001], 8'h11);
    do_op(0, 0, 2, 'h7FFE, 32'h0, 0);
    chk("wrap_read", p0_rdata, 32'h11223344);

    do_op(0, 1, 2, 'h0300, 32'h55667788, 1);
    do_op(1, 0, 2, 'h0300, 32'h0, 0);
    chk("disturb_read", p1_rdata, 32'h55667788);
    do_op(1, 0, 2, 'h0400, 32'h0, 0);
    chk("disturb_other", p1_rdata, 32'h00000000);

    // Reset lands while byte 2 of a word write is on the RAM bus.
    wait_idle();
    set_cmd(0, 1'b1, 1'b1, 2'd2, AW'('h2000), 32'hA1B2C3D4);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_we", ram_we, 1'b0);
    chk("midrst_addr", ram_addr, 32'h2002);
    @(posedge clk); #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ack", p0_ack, 1'b0);
    set_cmd(0, 1'b0, 1'b0, 2'd0, '0, 32'd0);
    rst_n = 1'b1;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
    ref_mem['h2000] = 8'hD4;
    ref_mem['h2001] = 8'hC3;
    chk("midrst_b0", mem['h2000], ref_mem['h2000]);
    chk("midrst_b1", mem['h2001], ref_mem['h2001]);
    chk("midrst_b2", mem['h2002], 8'h00);
    chk("midrst_b3", mem['h2003], 8'h00);
    @(posedge clk); #1;
    chk("midrst_no_late_ack", p0_ack, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int port = $urandom_range(0, 1);
      int sz   = $urandom_range(0, 3);
      int a    = ($urandom_range(0, 3) == 0) ? $urandom_range(MSZ - 4, MSZ - 1)
                                             : $urandom_range(0, 63);
      do_op(port, $urandom_range(0, 1), sz, a, $urandom, 0);
    end

    // Both ports request together and keep requesting.
    do_reset();
    @(posedge clk); #1;
    set_cmd(0, 1'b1, 1'b0, 2'd2, AW'('h0100), 32'd0);
    set_cmd(1, 1'b1, 1'b0, 2'd2, AW'('h7FFE), 32'd0);
    gcnt = 0;
    cyc  = 0;
    while (gcnt < 4 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      if (p0_ack || p1_ack) begin
        gid[gcnt] = p1_ack ? 1 : 0;
        if (p1_ack) chk("contend_p1_rdata", p1_rdata, ref_read('h7FFE, 4));
        else        chk("contend_p0_rdata", p0_rdata, ref_read('h0100, 4));
        gcnt++;
      end
    end
    set_cmd(0, 1'b0, 1'b0, 2'd0, '0, 32'd0);
    set_cmd(1, 1'b0, 1'b0, 2'd0, '0, 32'd0);
    chk("contend_count", gcnt, 4);
    for (int i = 0; i < gcnt; i++) begin
`ifdef RAM32K_ARB_RR_EN
      chk($sformatf("contend_grant%0d", i), gid[i], i % 2);
`else
      chk($sformatf("contend_grant%0d", i), gid[i], 0);
`endif
    end
    wait_idle();

    chk("acks_never_both", both_ack_cnt, 0);
    chk("we_outside_busy", idle_we_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
